// File: rtl/wb_port_arbiter_if.sv
// Write-port arbiter bus: pipeline writeback, multi-cycle result offer,
// register-file write port and stall/halt status.
interface wb_port_arbiter_if;
  localparam int unsigned RW_W   = 5;
  localparam int unsigned DATA_W = 32;

  logic              pipe_wen_in_wb;
  logic [RW_W-1:0]   pipe_rw_in_wb;
  logic [DATA_W-1:0] pipe_di_in_wb;
  logic              halt_in_wb;
  logic              mc_valid;
  logic [RW_W-1:0]   mc_rw;
  logic [DATA_W-1:0] mc_di;
  logic              mc_ready;
  logic              rf_wen_out;
  logic [RW_W-1:0]   rf_rw_out;
  logic [DATA_W-1:0] rf_di_out;
  logic              stall_out;
  logic              halt_out;

  // Pipeline / multi-cycle side
  modport master (
    output pipe_wen_in_wb, pipe_rw_in_wb, pipe_di_in_wb, halt_in_wb,
    output mc_valid, mc_rw, mc_di,
    input  mc_ready, rf_wen_out, rf_rw_out, rf_di_out, stall_out, halt_out
  );

  // Arbiter side
  modport slave (
    input  pipe_wen_in_wb, pipe_rw_in_wb, pipe_di_in_wb, halt_in_wb,
    input  mc_valid, mc_rw, mc_di,
    output mc_ready, rf_wen_out, rf_rw_out, rf_di_out, stall_out, halt_out
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority,
// multi-cycle results queue in a small FIFO and drain into idle/r0 cycles.
// Optional feature macro: WBARB_STARVE_EN (forced drain after STARVE_LIMIT
// consecutive lost arbitration cycles, signalled via stall_out).
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              CLK,
  input logic              RST,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned RW_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [RW_W-1:0]   rw;
    logic [DATA_W-1:0] di;
  } entry_t;

  // Only power-of-two depths 2/4 are supported (pointers wrap naturally)
  if (!(DEPTH == 2 || DEPTH == 4) || STARVE_LIMIT == 0) begin : g_bad_cfg
    $error("wb_port_arbiter: illegal DEPTH or STARVE_LIMIT");
  end

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_next;
  entry_t            head;
  logic              empty, full, push, pop;
  logic              pipe_win, collision, fifo_win;
  logic              rf_wen;
  logic [RW_W-1:0]   rf_rw;
  logic [DATA_W-1:0] rf_di;
  logic              halt_pending, halt_r, stall_r;

  // Arbitration and write-port mux
  always_comb begin
    rf_wen     = 1'b0;
    rf_rw      = '0;
    rf_di      = '0;
    head       = mem[rd_ptr];
    empty      = (count == '0);
    full       = (count == CNT_W'(DEPTH));
    push       = bus.mc_valid && !full && !RST;
    pipe_win   = !RST && bus.pipe_wen_in_wb && (bus.pipe_rw_in_wb != '0) && !stall_r;
    collision  = pipe_win && !empty && (head.rw == bus.pipe_rw_in_wb);
    fifo_win   = !RST && !pipe_win && !empty;
    pop        = collision || fifo_win;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    if (pipe_win) begin
      rf_wen = 1'b1;
      rf_rw  = bus.pipe_rw_in_wb;
      rf_di  = bus.pipe_di_in_wb;
    end else if (fifo_win && head.rw != '0) begin
      rf_wen = 1'b1;
      rf_rw  = head.rw;
      rf_di  = head.di;
    end
  end

  assign bus.mc_ready   = !full && !RST;
  assign bus.rf_wen_out = rf_wen;
  assign bus.rf_rw_out  = rf_rw;
  assign bus.rf_di_out  = rf_di;
  assign bus.stall_out  = stall_r;
  assign bus.halt_out   = halt_r;

  // FIFO storage (contents need no reset; occupancy is tracked separately)
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{rw: bus.mc_rw, di: bus.mc_di};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Halt completes once every queued result has been committed
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_pending <= 1'b0;
      halt_r       <= 1'b0;
    end else begin
      if (bus.halt_in_wb) halt_pending <= 1'b1;
      if (halt_pending && count_next == '0 && !bus.mc_valid) halt_r <= 1'b1;
    end
  end

`ifdef WBARB_STARVE_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  // Starvation counter: force one drain cycle after STARVE_LIMIT lost cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
      stall_r    <= 1'b0;
    end else begin
      stall_r <= 1'b0;
      if (pop) begin
        starve_cnt <= '0;
      end else if (pipe_win && !empty) begin
        if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) begin
          starve_cnt <= '0;
          stall_r    <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + SC_W'(1);
        end
      end
    end
  end
`else
  assign stall_r = 1'b0;
`endif
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and results from long-latency multi-cycle units (divider, uncached load). It sits between the writeback stage and the register file: multi-cycle results are queued in a small FIFO and drained into idle write-port cycles. Halt is reported only after every queued result has been committed.

## Interface
- DEPTH, 2, multi-cycle result FIFO entries; legal values 2 or 4.
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before a forced drain (only with WBARB_STARVE_EN).

- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; synchronous, active-high
- pipe_wen_in_wb  in  1  pipeline writeback valid this cycle
- pipe_rw_in_wb  in  5  pipeline destination register
- pipe_di_in_wb  in  32  pipeline write data
- halt_in_wb  in  1  halt instruction present in writeback
- mc_valid  in  1  multi-cycle result offered
- mc_rw  in  5  multi-cycle destination register
- mc_di  in  32  multi-cycle result data
- mc_ready  out  1  FIFO can accept; `mc_ready = !full && !RST`
- rf_wen_out  out  1  register-file write enable
- rf_rw_out  out  5  register-file write address
- rf_di_out  out  32  register-file write data
- stall_out  out  1  registered; pipeline must hold writeback contents this cycle
- halt_out  out  1  registered; sticky halt-complete

## Operation
- **Push:** on a cycle with `mc_valid && mc_ready`, {mc_rw, mc_di} is written at the tail. No push when full. Push and pop in the same cycle are allowed when not full; the count is then unchanged.
- **Pipeline win:** the pipeline wins when `pipe_wen_in_wb && pipe_rw_in_wb != 0 && !stall_out`.
  - The rf_* outputs carry the pipe values.
  - The FIFO head is not popped, except on a collision (next rule).
- **Collision:** the FIFO is non-empty, the pipeline wins, and head rw equals pipe_rw.
  - The head is popped and discarded in the same cycle; the pipeline write is architecturally newer.
  - Only the head is compared. The hazard unit guarantees at most one outstanding multi-cycle write per register.
- **FIFO win:** when the pipeline does not win and the FIFO is non-empty, the head is driven onto rf_* and popped.
  - An entry with rw=0 is popped without asserting rf_wen_out.
- **r0:** a pipeline write with rw=0 never asserts rf_wen_out, and it frees the port for the FIFO that cycle.
- **Output defaults:** rf_* outputs are combinational from the FIFO head and pipe inputs. When neither source writes, rf_wen_out=0, rf_rw_out=0, rf_di_out=0.
- **Halt:**
  - halt_in_wb sets an internal halt_pending flag.
  - halt_out rises on the edge after a cycle in which halt_pending=1, the FIFO is empty (after that cycle's pop) and mc_valid=0.
  - halt_out stays high until RST.
  - Pushes are still accepted while halt_pending is set.
- **Reset:** while RST=1, the FIFO is flushed, halt_pending=0, and the starvation counter is cleared.

## Timing
- Reset values: mc_ready=0, rf_wen_out=0, rf_rw_out=0, rf_di_out=0, stall_out=0, halt_out=0. rf_wen_out is forced to 0 while RST=1.
- Push-to-write latency is at least 1 cycle: an entry pushed in cycle N can be written in cycle N+1 at the earliest. There is no bypass.
- mc_ready deasserts in the cycle after the push that fills the FIFO, and reasserts in the cycle after the first pop.
- Drain order is FIFO order; write pointers wrap modulo DEPTH.
- RST asserted mid-operation discards all queued entries with no further writes. This includes an entry being offered in the same cycle.

## Configuration
- **WBARB_STARVE_EN defined:**
  - A counter increments on each cycle where the FIFO is non-empty and the pipeline wins. It clears on any pop.
  - When the counter reaches STARVE_LIMIT, stall_out=1 for exactly the next cycle and the counter clears.
  - In that cycle the FIFO head takes the port, and the pipeline holds its writeback values and re-presents them the following cycle.
- **WBARB_STARVE_EN undefined:** the counter is not built and stall_out is tied to 0. The FIFO drains only in idle or r0 cycles.

## Test plan
- **Reset:** RST=1 for 2 cycles with mc_valid=1 -> mc_ready=0, rf_wen_out=0, and no later write occurs after release.
- **Idle drain:** push rw=5, di=0x0000_1234 in cycle 0 with pipe idle -> cycle 1: rf_wen_out=1, rf_rw_out=5, rf_di_out=0x1234; mc_ready stays 1.
- **Priority and full (DEPTH=2):**
  - Pipe writes rw=3 every cycle while two entries are pushed (rw=8, rw=9) -> mc_ready=0 after the second push, and rf_* show only rw=3.
  - Pipe then goes idle -> rw=8 is written, then rw=9, in consecutive cycles.
- **r0 and collision:**
  - Pipe rw=0 with head rw=6 -> head rw=6 is written that cycle.
  - Head rw=7 with pipe rw=7, di=0xAA -> rf_di_out=0xAA, the head is discarded, and the count decrements by 1.
- **Halt:** one entry queued, pipe busy, halt_in_wb=1 -> halt_out stays 0 until the entry is written, then rises the next cycle and stays high until RST.
- **Starvation (WBARB_STARVE_EN, STARVE_LIMIT=4):**
  - One entry pushed in cycle 0 while the pipe writes rw=2 continuously.
  - Cycles 1–4: the pipe wins.
  - Cycle 5: stall_out=1 and the entry is written.
  - Cycle 6: stall_out=0 and the held pipe write is performed.
